// File: rtl/hamming_scrub_pkg.sv
// Shared types and defaults for the Hamming counter scrub controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hamming_scrub_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    FREEZE = 3'd2,
    CHECK  = 3'd3,
    RESUME = 3'd4
  } scrub_state_e;

  localparam int DEF_WIDTH        = 16;
  localparam int DEF_ERR_CNT_W    = 8;
  localparam int DEF_SCRUB_PERIOD = 256;
  localparam int DEF_CHECK_CYCLES = 4;
  localparam int DEF_TIMEOUT      = 16;

  // Larger of two sizes, used to size the shared check/timeout timer.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hamming_scrub_ctrl_if.sv
// Signal bundle between the scrub controller and the Hamming counter stage.
// Latency: n/a (wiring only).
// Backpressure: none; the counter stage paces the scrub through busy.
interface hamming_scrub_ctrl_if #(
  parameter int WIDTH     = 16,
  parameter int ERR_CNT_W = 8
);
  logic                 run_req;
  logic                 irq_clr;
  logic                 busy;
  logic                 error_detected;
  logic [WIDTH-1:0]     counter;
  logic                 cnt_enable;
  logic                 scrub_active;
  logic                 scrub_done;
  logic [ERR_CNT_W-1:0] err_count;
  logic [WIDTH-1:0]     last_err_value;
  logic                 err_irq;
  logic                 timeout_flag;

  // Controller side.
  modport master (
    input  run_req, irq_clr, busy, error_detected, counter,
    output cnt_enable, scrub_active, scrub_done, err_count,
           last_err_value, err_irq, timeout_flag
  );

  // Counter stage / software side.
  modport slave (
    output run_req, irq_clr, busy, error_detected, counter,
    input  cnt_enable, scrub_active, scrub_done, err_count,
           last_err_value, err_irq, timeout_flag
  );
endinterface

// File: rtl/hamming_scrub_ctrl_timer.sv
// Up-counter with synchronous clear, enable and terminal-count compare.
// Latency: count updates one cycle after en/clr; tc is combinational from the count.
// Backpressure: none.
module scrub_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  // Clear has priority over counting.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == tc_val);

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Scrub controller: runs the counter stage, freezes it every SCRUB_PERIOD cycles to check/reload it, logs errors.
// Latency: all outputs registered; cnt_enable follows run_req by one cycle. Optional macro SCRUB_TIMEOUT_EN adds a FREEZE watchdog.
// Backpressure: FREEZE holds until the counter stage raises busy (or the watchdog fires when enabled).
module hamming_scrub_ctrl
  import hamming_scrub_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int ERR_CNT_W    = DEF_ERR_CNT_W,
  parameter int SCRUB_PERIOD = DEF_SCRUB_PERIOD,
  parameter int CHECK_CYCLES = DEF_CHECK_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  hamming_scrub_ctrl_if.master bus
);

  // Period timer spans RUN; the second timer is shared by FREEZE (watchdog) and CHECK.
  localparam int PW = $clog2(SCRUB_PERIOD);
  localparam int CW = $clog2(max2(CHECK_CYCLES, TIMEOUT) + 1);

  scrub_state_e state_q, state_d;

  logic                 cnt_enable_q, cnt_enable_d;
  logic                 scrub_active_q, scrub_active_d;
  logic                 scrub_done_q, scrub_done_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0]     last_err_value_q, last_err_value_d;
  logic                 err_irq_q, err_irq_d;
  logic                 faulty_q, faulty_d;
`ifdef SCRUB_TIMEOUT_EN
  logic                 timeout_flag_q, timeout_flag_d;
`endif

  logic          per_en, per_clr, per_tc;
  logic          chk_en, chk_clr, chk_tc;
  logic [CW-1:0] chk_tc_val;

  scrub_timer #(.W(PW)) u_period_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (per_en),
    .clr    (per_clr),
    .tc_val (PW'(SCRUB_PERIOD - 1)),
    .tc     (per_tc)
  );

  scrub_timer #(.W(CW)) u_check_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (chk_en),
    .clr    (chk_clr),
    .tc_val (chk_tc_val),
    .tc     (chk_tc)
  );

  // The shared timer ends CHECK after CHECK_CYCLES cycles, or FREEZE after TIMEOUT cycles.
  always_comb begin
`ifdef SCRUB_TIMEOUT_EN
    chk_tc_val = (state_q == CHECK) ? CW'(CHECK_CYCLES - 1) : CW'(TIMEOUT - 1);
`else
    chk_tc_val = CW'(CHECK_CYCLES - 1);
`endif
  end

  // Next state, error bookkeeping and registered-output targets.
  always_comb begin
    state_d          = state_q;
    faulty_d         = faulty_q;
    err_count_d      = err_count_q;
    last_err_value_d = last_err_value_q;
    scrub_done_d     = 1'b0;
    // A set later in this block overrides the clear.
    err_irq_d        = bus.irq_clr ? 1'b0 : err_irq_q;
`ifdef SCRUB_TIMEOUT_EN
    timeout_flag_d   = bus.irq_clr ? 1'b0 : timeout_flag_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.run_req) state_d = RUN;
      end
      RUN: begin
        if (!bus.run_req) begin
          state_d = IDLE;
        end else if (per_tc) begin
          state_d = FREEZE;
        end
      end
      FREEZE: begin
        if (bus.busy) begin
          state_d = CHECK;
`ifdef SCRUB_TIMEOUT_EN
        end else if (chk_tc) begin
          // Counter stage never answered: abandon the scrub without a done pulse.
          state_d        = RESUME;
          timeout_flag_d = 1'b1;
`endif
        end
      end
      CHECK: begin
        if (bus.error_detected) begin
          faulty_d = 1'b1;
          if (!faulty_q) last_err_value_d = bus.counter;
        end
        if (chk_tc) begin
          state_d      = RESUME;
          scrub_done_d = 1'b1;
          faulty_d     = 1'b0;
          if (faulty_q || bus.error_detected) begin
            err_irq_d = 1'b1;
            if (err_count_q != {ERR_CNT_W{1'b1}}) err_count_d = err_count_q + 1'b1;
          end
        end
      end
      RESUME: begin
        // Enable stays low this cycle so the stage loads its corrected value.
        state_d = bus.run_req ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    per_en         = (state_q == RUN);
    per_clr        = (state_d != RUN);
    chk_en         = (state_q == FREEZE) || (state_q == CHECK);
    chk_clr        = (state_d != state_q);
    cnt_enable_d   = (state_d == RUN);
    scrub_active_d = (state_d == FREEZE) || (state_d == CHECK);
  end

  // State and output registers; reset aborts any scrub in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      cnt_enable_q     <= 1'b0;
      scrub_active_q   <= 1'b0;
      scrub_done_q     <= 1'b0;
      err_count_q      <= '0;
      last_err_value_q <= '0;
      err_irq_q        <= 1'b0;
      faulty_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_enable_q     <= cnt_enable_d;
      scrub_active_q   <= scrub_active_d;
      scrub_done_q     <= scrub_done_d;
      err_count_q      <= err_count_d;
      last_err_value_q <= last_err_value_d;
      err_irq_q        <= err_irq_d;
      faulty_q         <= faulty_d;
    end
  end

`ifdef SCRUB_TIMEOUT_EN
  // Sticky watchdog flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_flag_q <= 1'b0;
    end else begin
      timeout_flag_q <= timeout_flag_d;
    end
  end
  assign bus.timeout_flag = timeout_flag_q;
`else
  assign bus.timeout_flag = 1'b0;
`endif

  assign bus.cnt_enable     = cnt_enable_q;
  assign bus.scrub_active   = scrub_active_q;
  assign bus.scrub_done     = scrub_done_q;
  assign bus.err_count      = err_count_q;
  assign bus.last_err_value = last_err_value_q;
  assign bus.err_irq        = err_irq_q;

endmodule
